// File: rtl/game_flow_controller.sv
// Breakout game sequencer: IDLE -> SERVE -> PLAY -> LOST/CLEAR -> ... -> OVER, owning lives and level.
// Optional pause feature is enabled by defining PAUSE_EN.
module game_flow_controller #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned MAX_LEVEL   = 8,
  parameter int unsigned LIVES_W     = 3,
  parameter int unsigned LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               ball_lost,
  input  logic               bricks_cleared,
  input  logic               game_over_complete,
  output logic               trigger_game_over,
  output logic               serve_ball,
  output logic               reload_bricks,
  output logic               play_enable,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state
);

  localparam int unsigned TIMER_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_LOST   = 3'd3,
    S_CLEAR  = 3'd4,
    S_OVER   = 3'd5,
    S_PAUSED = 3'd6
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [TIMER_W-1:0] timer;
  logic               start_q;
  logic               start_rise;
  logic               serve_done;

  assign start_rise = start_btn & ~start_q;
  assign serve_done = (timer == TIMER_W'(SERVE_DELAY - 1));
  assign state      = state_q;

`ifdef PAUSE_EN
  logic pause_q;
  logic pause_rise;

  assign pause_rise = pause_btn & ~pause_q;

  // Pause edge detector; reset high so a held button is not seen as an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pause_q <= 1'b1;
    else          pause_q <= pause_btn;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  // State register and start edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= start_btn;
    end
  end

  // Next-state logic; bricks_cleared outranks ball_lost in PLAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_rise) state_d = S_SERVE;
      S_SERVE: if (serve_done) state_d = S_PLAY;
      S_PLAY: begin
        if (bricks_cleared) state_d = S_CLEAR;
        else if (ball_lost) state_d = S_LOST;
`ifdef PAUSE_EN
        else if (pause_rise) state_d = S_PAUSED;
`endif
      end
      S_LOST:  state_d = (lives <= LIVES_W'(1)) ? S_OVER : S_SERVE;
      S_CLEAR: state_d = S_SERVE;
      // First OVER cycle is marked by the trigger pulse; completion is ignored then
      S_OVER:  if (!trigger_game_over && game_over_complete) state_d = S_IDLE;
`ifdef PAUSE_EN
      S_PAUSED: if (pause_rise) state_d = S_PLAY;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, serve timer and game counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer             <= '0;
      reload_bricks     <= 1'b0;
      serve_ball        <= 1'b0;
      trigger_game_over <= 1'b0;
      play_enable       <= 1'b0;
      lives             <= LIVES_W'(START_LIVES);
      level             <= LEVEL_W'(1);
    end else begin
      timer             <= (state_q == S_SERVE && state_d == S_SERVE) ? timer + TIMER_W'(1) : '0;
      reload_bricks     <= (state_d == S_SERVE) && (state_q == S_IDLE || state_q == S_CLEAR);
      serve_ball        <= (state_q == S_SERVE) && (state_d == S_PLAY);
      trigger_game_over <= (state_d == S_OVER) && (state_q != S_OVER);
      play_enable       <= (state_d == S_PLAY);
      if (state_d == S_IDLE) begin
        lives <= LIVES_W'(START_LIVES);
        level <= LEVEL_W'(1);
      end else begin
        if (state_q == S_LOST && lives != '0) lives <= lives - LIVES_W'(1);
        if (state_q == S_CLEAR)
          level <= (level == LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(1) : level + LEVEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: a game-level model predicts pulse events
// (kind, cycle, lives, level) into a queue; a negedge monitor pops and compares them.
module tb_game_flow_controller;

  localparam int SD = 4;
  localparam int SL = 3;
  localparam int ML = 2;

  localparam int K_RELOAD = 1;
  localparam int K_SERVE  = 2;
  localparam int K_TRIG   = 4;

  logic       clk;
  logic       reset_n;
  logic       start_btn;
  logic       pause_btn;
  logic       ball_lost;
  logic       bricks_cleared;
  logic       game_over_complete;
  logic       trigger_game_over;
  logic       serve_ball;
  logic       reload_bricks;
  logic       play_enable;
  logic [2:0] lives;
  logic [3:0] level;
  logic [2:0] state;

  game_flow_controller #(
    .START_LIVES(SL), .SERVE_DELAY(SD), .MAX_LEVEL(ML), .LIVES_W(3), .LEVEL_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .pause_btn(pause_btn),
    .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
    .game_over_complete(game_over_complete), .trigger_game_over(trigger_game_over),
    .serve_ball(serve_ball), .reload_bricks(reload_bricks), .play_enable(play_enable),
    .lives(lives), .level(level), .state(state)
  );

  typedef struct {
    int kind;
    int cyc;
    int lives;
    int level;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Game-level model
  int m_lives = SL;
  int m_level = 1;
  bit m_idle  = 1;
  int play_at = 0;
  int last_start = 0;
  int last_evt = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5 cyc++;
      clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int lv, input int lvl);
    ev_t e;
    e.kind = kind; e.cyc = c; e.lives = lv; e.level = lvl;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int t);
    while (cyc < t) step();
    @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest predicted event
  always @(negedge clk) begin
    if (reset_n && (reload_bricks || serve_ball || trigger_game_over)) begin
      int kind;
      ev_t e;
      kind = {29'd0, trigger_game_over, serve_ball, reload_bricks};
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d got_kind=%0d expected=none", cyc, kind);
      end else begin
        e = q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_lives", int'(lives), e.lives);
        check("pulse_level", int'(level), e.level);
      end
    end
  end

  task automatic do_start();
    step();
    start_btn = 1'b1;
    last_start = cyc;
    push(K_RELOAD, cyc + 1, m_lives, m_level);
    push(K_SERVE, cyc + 1 + SD, m_lives, m_level);
    play_at = cyc + 1 + SD;
    m_idle = 0;
    step();
    start_btn = 1'b0;
  endtask

  // Wait until PLAY; occasionally fire an event during SERVE that must be ignored
  task automatic wait_play(input int extra);
    while (cyc < play_at + extra) begin
      ball_lost = (cyc == play_at - 2) ? 1'($urandom_range(1)) : 1'b0;
      step();
    end
    ball_lost = 1'b0;
    @(negedge clk);
    check("play_state", int'(state), 2);
    check("play_enable", int'(play_enable), 1);
  endtask

  // kind: 0 ball lost, 1 bricks cleared, 2 both in the same cycle
  task automatic do_event(input int kind);
    int k;
    int d;
    int idle_at;
    k = cyc;
    last_evt = k;
    ball_lost      = (kind != 1);
    bricks_cleared = (kind != 0);
    if (kind != 0) begin
      m_level = (m_level == ML) ? 1 : m_level + 1;
      push(K_RELOAD, k + 2, m_lives, m_level);
      push(K_SERVE, k + 2 + SD, m_lives, m_level);
      play_at = k + 2 + SD;
    end else if (m_lives == 1) begin
      m_lives = 0;
      push(K_TRIG, k + 2, 0, m_level);
    end else begin
      m_lives = m_lives - 1;
      push(K_SERVE, k + 2 + SD, m_lives, m_level);
      play_at = k + 2 + SD;
    end
    step();
    ball_lost = 1'b0;
    bricks_cleared = 1'b0;
    if (kind == 0 && m_lives == 0) begin
      d = $urandom_range(3);
      while (cyc < k + 2 + d) step();
      game_over_complete = 1'b1;
      idle_at = (d == 0) ? k + 4 : k + 3 + d;
      sample(idle_at - 1);
      check("over_state", int'(state), 5);
      sample(idle_at);
      check("idle_state", int'(state), 0);
      check("idle_lives", int'(lives), SL);
      check("idle_level", int'(level), 1);
      game_over_complete = 1'b0;
      m_lives = SL;
      m_level = 1;
      m_idle = 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_btn = 1'b1;
    pause_btn = 1'b0;
    ball_lost = 1'b0;
    bricks_cleared = 1'b0;
    game_over_complete = 1'b0;
    #50;
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), SL);
    check("rst_level", int'(level), 1);
    check("rst_pulses", int'({trigger_game_over, serve_ball, reload_bricks}), 0);
    check("rst_play_enable", int'(play_enable), 0);
    #53 reset_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("held_start_idle", int'(state), 0);
    start_btn = 1'b0;
    repeat (2) step();

    // Start: SERVE for exactly SD cycles, then PLAY
    do_start();
    sample(last_start + 1);
    check("serve_first", int'(state), 1);
    sample(last_start + SD);
    check("serve_last", int'(state), 1);
    sample(last_start + SD + 1);
    check("play_after_serve", int'(state), 2);

    // Three lost balls end the game
    repeat (3) begin
      wait_play(1);
      do_event(0);
    end

    // Simultaneous clear and loss, then clear again to wrap the level
    do_start();
    wait_play(0);
    do_event(2);
    wait_play(2);
    do_event(1);

    // Pause handling
    wait_play(1);
    begin
      int k;
      k = cyc;
      pause_btn = 1'b1;
      step();
`ifdef PAUSE_EN
      ball_lost = 1'b1;
      @(negedge clk);
      check("pause_state", int'(state), 6);
      check("pause_play_enable", int'(play_enable), 0);
`else
      @(negedge clk);
      check("pause_state", int'(state), 2);
      check("pause_play_enable", int'(play_enable), 1);
`endif
      step();
      ball_lost = 1'b0;
      pause_btn = 1'b0;
      step();
      pause_btn = 1'b1;
      sample(k + 4);
      check("resume_state", int'(state), 2);
      check("resume_play_enable", int'(play_enable), 1);
      check("resume_lives", int'(lives), m_lives);
      pause_btn = 1'b0;
    end

    // Randomized play
    for (int i = 0; i < 24; i++) begin
      if (m_idle) do_start();
      wait_play(int'($urandom_range(3)));
      do_event(int'($urandom_range(2)));
    end

    // Async reset in the middle of SERVE (timer at 2)
    if (m_idle) do_start();
    wait_play(0);
    do_event(1);
    while (cyc < last_evt + 4) step();
    #1 reset_n = 1'b0;
    #1;
    check("areset_state", int'(state), 0);
    check("areset_pulses", int'({trigger_game_over, serve_ball, reload_bricks}), 0);
    check("areset_play_enable", int'(play_enable), 0);
    check("areset_lives", int'(lives), SL);
    check("areset_level", int'(level), 1);
    q.delete();
    m_lives = SL;
    m_level = 1;
    m_idle = 1;
    #4 reset_n = 1'b1;
    step();
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    sample(cyc + 2);
    check("idle_lost_state", int'(state), 0);
    check("idle_lost_lives", int'(lives), SL);

    repeat (10) step();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
